// File: rtl/cache_pkg.sv
// ----------------------------------------------------------------------------
// cache_pkg
//   Shared definitions for the data-cache miss handler.
//   - Default cache geometry (address width, word width, words per block)
//   - WORD_BYTES : bytes per memory word
//   - refill_state_t : 2-bit refill FSM state encoding
//   - blk_base() : clears the byte-within-block offset of an address
// ----------------------------------------------------------------------------
package cache_pkg;

  localparam int CACHE_ADDR_WIDTH      = 32;
  localparam int CACHE_DATA_WIDTH      = 32;
  localparam int CACHE_WORDS_PER_BLOCK = 4;

  localparam int WORD_BYTES     = CACHE_DATA_WIDTH / 8;
  localparam int BLOCK_OFF_BITS = $clog2(CACHE_WORDS_PER_BLOCK * WORD_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WB    = 2'd1,
    ST_FETCH = 2'd2,
    ST_FILL  = 2'd3
  } refill_state_t;

  // Block-aligned base of a byte address.
  function automatic logic [CACHE_ADDR_WIDTH-1:0] blk_base(
    input logic [CACHE_ADDR_WIDTH-1:0] addr
  );
    logic [CACHE_ADDR_WIDTH-1:0] mask;
    mask = '1;
    mask = mask << BLOCK_OFF_BITS;
    return addr & mask;
  endfunction

endpackage

// File: rtl/dcache_refill_ctrl_if.sv
// ----------------------------------------------------------------------------
// dcache_refill_ctrl_if
//   Word-serial memory bus between the refill controller (master) and main
//   memory (slave).
//   Signals:
//     mem_read / mem_write  strobes, never high together
//     mem_addr              word-aligned byte address
//     mem_writedata         write data
//     mem_readdata          read data, valid when mem_ack=1
//     mem_ack               transfer completes on the rising edge where it is 1
//
//   Handshake: the master raises one strobe and holds strobe, mem_addr and
//   mem_writedata stable until a rising edge with mem_ack=1; that edge
//   completes the transfer. The strobe may stay high for the next word
//   (back-to-back). mem_ack has no meaning while both strobes are low.
// ----------------------------------------------------------------------------
interface dcache_refill_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_writedata;
  logic [DATA_WIDTH-1:0] mem_readdata;
  logic                  mem_ack;

  modport master (
    output mem_read, mem_write, mem_addr, mem_writedata,
    input  mem_readdata, mem_ack
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_writedata,
    output mem_readdata, mem_ack
  );

endinterface

// File: rtl/refill_word_buffer.sv
// ----------------------------------------------------------------------------
// refill_word_buffer
//   WORDS x DATA_WIDTH register file collecting the words of a block being
//   fetched.
//   Ports:
//     clk, reset  clock, synchronous active-high reset (clears all words)
//     we          write enable for one word
//     waddr       word index written
//     wdata       word written
//     rd_flat     all words, word i at bits [i*DATA_WIDTH +: DATA_WIDTH]
// ----------------------------------------------------------------------------
module refill_word_buffer #(
  parameter int WORDS      = 4,
  parameter int DATA_WIDTH = 32,
  localparam int IDXW      = $clog2(WORDS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we,
  input  logic [IDXW-1:0]             waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  output logic [WORDS*DATA_WIDTH-1:0] rd_flat
);

  logic [DATA_WIDTH-1:0] word_q [WORDS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) word_q[i] <= '0;
    end else if (we) begin
      word_q[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < WORDS; g++) begin : g_flat
    assign rd_flat[g*DATA_WIDTH +: DATA_WIDTH] = word_q[g];
  end

endmodule

// File: rtl/dcache_refill_ctrl.sv
// ----------------------------------------------------------------------------
// dcache_refill_ctrl
//   Miss handler behind the set-associative data cache. On a miss it writes
//   back a dirty victim block word by word, fetches the missing block word by
//   word, and returns the whole block to the cache in a one-cycle fill pulse.
//   Ports:
//     clk, reset               clock, synchronous active-high reset
//     miss_valid, miss_addr    refill request (level) and missing byte address
//     victim_dirty/addr/data   victim block to write back when dirty
//     miss_busy                stall to the cache while a miss is in service
//     fill_valid/addr/data     one-cycle fill of the refilled block
//     crit_valid, crit_data    early-restart word (REFILL_CRITICAL_WORD_FIRST_EN only)
//     dbg_state                current FSM state
//     mem                      memory bus, master side
//   Build option: define REFILL_CRITICAL_WORD_FIRST_EN to fetch starting at
//   the missed word (wrapping) and to add the crit_* outputs.
// ----------------------------------------------------------------------------
module dcache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH      = CACHE_ADDR_WIDTH,
  parameter int DATA_WIDTH      = CACHE_DATA_WIDTH,
  parameter int WORDS_PER_BLOCK = CACHE_WORDS_PER_BLOCK
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  miss_valid,
  input  logic [ADDR_WIDTH-1:0]                 miss_addr,
  input  logic                                  victim_dirty,
  input  logic [ADDR_WIDTH-1:0]                 victim_addr,
  input  logic [WORDS_PER_BLOCK*DATA_WIDTH-1:0] victim_data,
  output logic                                  miss_busy,
  output logic                                  fill_valid,
  output logic [ADDR_WIDTH-1:0]                 fill_addr,
  output logic [WORDS_PER_BLOCK*DATA_WIDTH-1:0] fill_data,
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  output logic                                  crit_valid,
  output logic [DATA_WIDTH-1:0]                 crit_data,
`endif
  output refill_state_t                         dbg_state,
  dcache_refill_ctrl_if.master                  mem
);

  localparam int IDXW       = $clog2(WORDS_PER_BLOCK);
  localparam int WORD_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS_PER_BLOCK - 1);

  refill_state_t state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0]                 base_q;
  logic [ADDR_WIDTH-1:0]                 victim_base_q;
  logic [WORDS_PER_BLOCK*DATA_WIDTH-1:0] victim_q;
  logic [WORDS_PER_BLOCK*DATA_WIDTH-1:0] fill_data_q;
  logic [WORDS_PER_BLOCK*DATA_WIDTH-1:0] buf_flat;
  logic [WORDS_PER_BLOCK*DATA_WIDTH-1:0] fill_next;

  logic            accept;
  logic            fetch_ack;
  logic            last_fetch;
  logic [IDXW-1:0] fetch_idx;

  function automatic logic [ADDR_WIDTH-1:0] word_off(input logic [IDXW-1:0] idx);
    return ADDR_WIDTH'(idx) << WORD_SHIFT;
  endfunction

  assign accept     = (state_q == ST_IDLE) && miss_valid;
  assign fetch_ack  = (state_q == ST_FETCH) && mem.mem_ack;
  assign last_fetch = fetch_ack && (cnt_q == LAST_IDX);

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  logic [IDXW-1:0]       start_q;
  logic                  crit_valid_q;
  logic [DATA_WIDTH-1:0] crit_data_q;
  // cnt_q counts completed transfers; the word index wraps in IDXW bits.
  assign fetch_idx  = cnt_q + start_q;
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
`else
  assign fetch_idx  = cnt_q;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- FSM: next state and bus outputs ----------------
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    mem.mem_read      = 1'b0;
    mem.mem_write     = 1'b0;
    mem.mem_addr      = '0;
    mem.mem_writedata = '0;
    case (state_q)
      ST_IDLE: begin
        if (miss_valid) begin
          state_d = victim_dirty ? ST_WB : ST_FETCH;
          cnt_d   = '0;
        end
      end
      ST_WB: begin
        mem.mem_write     = 1'b1;
        mem.mem_addr      = victim_base_q | word_off(cnt_q);
        mem.mem_writedata = victim_q[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH];
        if (mem.mem_ack) begin
          if (cnt_q == LAST_IDX) begin
            state_d = ST_FETCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + IDXW'(1);
          end
        end
      end
      ST_FETCH: begin
        mem.mem_read = 1'b1;
        mem.mem_addr = base_q | word_off(fetch_idx);
        if (mem.mem_ack) begin
          if (cnt_q == LAST_IDX) begin
            state_d = ST_FILL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + IDXW'(1);
          end
        end
      end
      ST_FILL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Final word is merged in directly so the fill register is ready on the
  // same edge the FSM enters FILL.
  always_comb begin
    fill_next = buf_flat;
    fill_next[int'(fetch_idx)*DATA_WIDTH +: DATA_WIDTH] = mem.mem_readdata;
  end

  // ---------------- capture and fill registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q        <= '0;
      victim_base_q <= '0;
      victim_q      <= '0;
      fill_data_q   <= '0;
    end else begin
      if (accept) begin
        base_q        <= blk_base(miss_addr);
        victim_base_q <= blk_base(victim_addr);
        victim_q      <= victim_data;
      end
      if (last_fetch) fill_data_q <= fill_next;
    end
  end

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q      <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      if (accept) start_q <= miss_addr[WORD_SHIFT +: IDXW];
      crit_valid_q <= fetch_ack && (cnt_q == '0);
      if (fetch_ack && (cnt_q == '0)) crit_data_q <= mem.mem_readdata;
    end
  end
`endif

  refill_word_buffer #(
    .WORDS      (WORDS_PER_BLOCK),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .we      (fetch_ack),
    .waddr   (fetch_idx),
    .wdata   (mem.mem_readdata),
    .rd_flat (buf_flat)
  );

  assign miss_busy  = (state_q != ST_IDLE);
  assign fill_valid = (state_q == ST_FILL);
  assign fill_addr  = base_q;
  assign fill_data  = fill_data_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
module tb_dcache_refill_ctrl;
  import cache_pkg::*;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int WPB       = 4;
  localparam int BW        = WPB * DW;
  localparam int BLK_BYTES = WPB * DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic          miss_valid = 1'b0;
  logic [AW-1:0] miss_addr = '0;
  logic          victim_dirty = 1'b0;
  logic [AW-1:0] victim_addr = '0;
  logic [BW-1:0] victim_data = '0;
  logic          miss_busy, fill_valid;
  logic [AW-1:0] fill_addr;
  logic [BW-1:0] fill_data;
  refill_state_t dbg_state;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  logic          crit_valid;
  logic [DW-1:0] crit_data;
`endif

  dcache_refill_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem ();

  dcache_refill_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .miss_valid   (miss_valid),
    .miss_addr    (miss_addr),
    .victim_dirty (victim_dirty),
    .victim_addr  (victim_addr),
    .victim_data  (victim_data),
    .miss_busy    (miss_busy),
    .fill_valid   (fill_valid),
    .fill_addr    (fill_addr),
    .fill_data    (fill_data),
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    .crit_valid   (crit_valid),
    .crit_data    (crit_data),
`endif
    .dbg_state    (dbg_state),
    .mem          (mem)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mem_exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
    int            acc_cyc;
    int            lat;
  } fill_exp_t;

  mem_exp_t      exp_mem_q[$];
  fill_exp_t     exp_fill_q[$];
  logic [DW-1:0] exp_crit_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- memory contents ----------------
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
  endfunction

  logic [DW-1:0] env_mem [logic [AW-1:0]];  // memory seen by the DUT
  logic [DW-1:0] ref_mem [logic [AW-1:0]];  // reference model's memory

  function automatic logic [DW-1:0] env_rd(input logic [AW-1:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_word(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // ---------------- reference model ----------------
  task automatic predict(input logic [AW-1:0] ma, input logic dirty, input logic [AW-1:0] va,
                         input logic [BW-1:0] vd, input int acc, input bit lat_on);
    fill_exp_t     fe;
    mem_exp_t      me;
    logic [AW-1:0] base, vbase, a;
    logic [DW-1:0] w;
    int            c, k;
    base  = ma - (ma % BLK_BYTES);
    vbase = va - (va % BLK_BYTES);
    if (dirty) begin
      for (int i = 0; i < WPB; i++) begin
        a = vbase + AW'(i * 4);
        w = vd[i*DW +: DW];
        ref_mem[a] = w;
        me.we = 1'b1; me.addr = a; me.data = w;
        exp_mem_q.push_back(me);
      end
    end
    c = 0;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    c = int'((ma % BLK_BYTES) / 4);
`endif
    fe.data = '0;
    for (int i = 0; i < WPB; i++) begin
      k = (c + i) % WPB;
      a = base + AW'(k * 4);
      w = ref_rd(a);
      me.we = 1'b0; me.addr = a; me.data = w;
      exp_mem_q.push_back(me);
      fe.data[k*DW +: DW] = w;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
      if (i == 0) exp_crit_q.push_back(w);
`endif
    end
    fe.addr    = base;
    fe.acc_cyc = acc;
    fe.lat     = lat_on ? (dirty ? 1 + 2 * WPB : 1 + WPB) : -1;
    exp_fill_q.push_back(fe);
  endtask

  // ---------------- memory responder ----------------
  int ack_mode = 0;  // 0: always ack, 1: every 3rd cycle, 2: random
  int ack_ph = 0;
  initial begin
    logic ack;
    mem.mem_ack = 1'b0;
    mem.mem_readdata = '0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0: ack = 1'b1;
        1: begin ack_ph = (ack_ph + 1) % 3; ack = (ack_ph == 0); end
        default: ack = ($urandom_range(0, 2) == 0);
      endcase
      mem.mem_ack = ack;
      mem.mem_readdata = ack ? env_rd(mem.mem_addr) : DW'($urandom);
    end
  end

  // ---------------- monitor ----------------
  logic          pend = 1'b0;
  logic          pend_rd, pend_wr;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_wd;

  always @(negedge clk) begin
    mem_exp_t  me;
    fill_exp_t fe;
    logic      strobe;
    if (reset) begin
      pend = 1'b0;
    end else begin
      strobe = mem.mem_read || mem.mem_write;
      if (strobe) chk("strobe_excl", BW'(mem.mem_read && mem.mem_write), '0);
      if (pend) begin
        chk("hold_rd", BW'(mem.mem_read), BW'(pend_rd));
        chk("hold_wr", BW'(mem.mem_write), BW'(pend_wr));
        chk("hold_addr", BW'(mem.mem_addr), BW'(pend_addr));
        if (pend_wr) chk("hold_wdata", BW'(mem.mem_writedata), BW'(pend_wd));
      end
      if (strobe && mem.mem_ack) begin
        pend = 1'b0;
        if (exp_mem_q.size() == 0) begin
          fail("unexpected_mem_xfer");
        end else begin
          me = exp_mem_q.pop_front();
          chk("xfer_kind_write", BW'(mem.mem_write), BW'(me.we));
          chk("xfer_addr", BW'(mem.mem_addr), BW'(me.addr));
          if (me.we) chk("wb_data", BW'(mem.mem_writedata), BW'(me.data));
        end
        if (mem.mem_write) env_mem[mem.mem_addr] = mem.mem_writedata;
      end else if (strobe) begin
        pend      = 1'b1;
        pend_rd   = mem.mem_read;
        pend_wr   = mem.mem_write;
        pend_addr = mem.mem_addr;
        pend_wd   = mem.mem_writedata;
      end else begin
        pend = 1'b0;
      end
      if (fill_valid) begin
        if (exp_fill_q.size() == 0) begin
          fail("unexpected_fill");
        end else begin
          fe = exp_fill_q.pop_front();
          chk("fill_addr", BW'(fill_addr), BW'(fe.addr));
          chk("fill_data", fill_data, fe.data);
          if (fe.lat >= 0) chk("fill_latency", BW'(cyc - fe.acc_cyc), BW'(fe.lat));
        end
      end
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
      if (crit_valid) begin
        if (exp_crit_q.size() == 0) fail("unexpected_crit");
        else chk("crit_data", BW'(crit_data), BW'(exp_crit_q.pop_front()));
      end
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_fill();
    bit got = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (fill_valid) begin got = 1; break; end
    end
    if (!got) fail("fill_timeout");
  endtask

  task automatic do_miss(input logic [AW-1:0] ma, input logic dirty, input logic [AW-1:0] va,
                         input logic [BW-1:0] vd, input bit hold);
    @(negedge clk);
    miss_valid   = 1'b1;
    miss_addr    = ma;
    victim_dirty = dirty;
    victim_addr  = va;
    victim_data  = vd;
    predict(ma, dirty, va, vd, cyc, ack_mode == 0);
    wait_fill();
    if (!hold) miss_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_miss_busy"}, BW'(miss_busy), '0);
    chk({tag, "_fill_valid"}, BW'(fill_valid), '0);
    chk({tag, "_mem_read"}, BW'(mem.mem_read), '0);
    chk({tag, "_mem_write"}, BW'(mem.mem_write), '0);
    chk({tag, "_mem_addr"}, BW'(mem.mem_addr), '0);
    chk({tag, "_mem_wdata"}, BW'(mem.mem_writedata), '0);
    chk({tag, "_fill_addr"}, BW'(fill_addr), '0);
    chk({tag, "_fill_data"}, fill_data, '0);
    chk({tag, "_state"}, BW'(dbg_state), BW'(ST_IDLE));
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    chk({tag, "_crit_valid"}, BW'(crit_valid), '0);
`endif
  endtask

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] b;
    for (int i = 0; i < WPB; i++) b[i*DW +: DW] = DW'($urandom);
    return b;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [BW-1:0] vd;
    bit            hit;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // clean miss, zero-wait memory
    ack_mode = 0;
    do_miss(32'h0000_1234, 1'b0, 32'h0, '0, 1'b0);

    // dirty miss: write-back of 0x2000 block, then fetch
    vd = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
    do_miss(32'h0000_1234, 1'b1, 32'h0000_2000, vd, 1'b0);

    // wait states: ack every 3rd cycle
    ack_mode = 1;
    do_miss(32'h0000_1234, 1'b0, 32'h0, '0, 1'b0);
    do_miss(32'h0000_1238, 1'b1, 32'h0000_1230, rand_block(), 1'b0);

    // reset during the 2nd fetch word
    ack_mode = 0;
    @(negedge clk);
    miss_valid = 1'b1; miss_addr = 32'h0000_3000; victim_dirty = 1'b0;
    predict(32'h0000_3000, 1'b0, 32'h0, '0, cyc, 1'b1);
    hit = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dbg_state == ST_FETCH && mem.mem_addr == 32'h0000_3004) begin hit = 1; break; end
    end
    if (!hit) fail("reset_point_not_reached");
    reset = 1'b1;
    miss_valid = 1'b0;
    @(posedge clk);
    #1;
    exp_mem_q.delete();
    exp_fill_q.delete();
    exp_crit_q.delete();
    @(negedge clk);
    check_idle_outputs("midreset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("after_reset_no_busy", BW'(miss_busy), '0);
    do_miss(32'h0000_3008, 1'b0, 32'h0, '0, 1'b0);

    // miss_valid held one cycle past fill: second refill
    do_miss(32'h0000_0040, 1'b0, 32'h0, '0, 1'b1);
    @(negedge clk);
    predict(32'h0000_0040, 1'b0, 32'h0, '0, cyc, 1'b1);
    @(negedge clk);
    miss_valid = 1'b0;
    wait_fill();
    repeat (3) begin
      @(negedge clk);
      chk("idle_after_drop_busy", BW'(miss_busy), '0);
      chk("idle_after_drop_state", BW'(dbg_state), BW'(ST_IDLE));
    end

    // critical-word-first case (plain order in the default build)
    do_miss(32'h0000_1238, 1'b0, 32'h0, '0, 1'b0);

    // randomized misses
    for (int n = 0; n < 30; n++) begin
      ack_mode = $urandom_range(0, 2);
      do_miss(AW'($urandom_range(0, 255) * 4), 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, 63) * BLK_BYTES), rand_block(), 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("mem_q_drained", BW'(exp_mem_q.size()), '0);
    chk("fill_q_drained", BW'(exp_fill_q.size()), '0);
    chk("crit_q_drained", BW'(exp_crit_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // hard time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

endmodule
